// File: rtl/fixed_pow.sv
// Iterative Q10.10 power unit: out_data = in_data_1 ^ in_data_2, saturated to MAXV.
// Optional build macro FIXED_POW_ROUND_EN selects round-half-up instead of truncation.
module fixed_pow #(
   parameter logic [19:0] ONE  = 20'h00400,
   parameter logic [19:0] MAXV = 20'hFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [19:0] in_data_1,
   input  logic [2:0]  in_data_2,
   output logic        out_valid,
   output logic [19:0] out_data,
   output logic        out_ovf
);

   // Handshake: in_valid is a single-cycle strobe that is taken only in IDLE
   // (strobes during MUL are dropped); out_valid is a single-cycle strobe and
   // out_data/out_ovf read 0 in every cycle where out_valid is low.
   typedef enum logic {IDLE, MUL} state_t;

   state_t      state;
   logic [19:0] x_q;
   logic [19:0] acc;
   logic [2:0]  cnt;
   logic        sat;

`ifdef FIXED_POW_ROUND_EN
   localparam logic [39:0] RND = 40'd512;
`else
   localparam logic [39:0] RND = 40'd0;
`endif

   logic [39:0] prod;
   logic [39:0] shifted;
   logic        res_ovf;

   // (2^20-1)^2 + 2^9 still fits in 40 bits, so the rounding add cannot wrap.
   always_comb begin
      prod    = 40'(acc) * 40'(x_q);
      shifted = (prod + RND) >> 10;
      res_ovf = |shifted[39:20];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         x_q       <= '0;
         acc       <= '0;
         cnt       <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_q   <= in_data_1;
                  cnt   <= in_data_2;
                  acc   <= ONE;
                  sat   <= 1'b0;
                  state <= MUL;
               end
            end
            MUL: begin
               if (cnt != 3'd0) begin
                  // Once saturated, stay pinned at MAXV for the remaining steps.
                  if (res_ovf || sat) begin
                     acc <= MAXV;
                     sat <= 1'b1;
                  end else begin
                     acc <= shifted[19:0];
                  end
                  cnt <= cnt - 3'd1;
               end else begin
                  out_valid <= 1'b1;
                  out_data  <= acc;
                  out_ovf   <= sat;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_pow.sv
// Directed plus randomized checks of fixed_pow against an arithmetic reference model.
module tb_fixed_pow;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [19:0] in_data_1;
   logic [2:0]  in_data_2;
   logic        out_valid;
   logic [19:0] out_data;
   logic        out_ovf;

   int n_checks = 0;
   int n_fail   = 0;
   logic [20:0] exp_q[$];

   fixed_pow dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data_1 (in_data_1),
      .in_data_2 (in_data_2),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // reference: x^n by repeated real-valued multiply in units of 1/1024
   function automatic logic [20:0] model(input logic [19:0] x, input int n);
      longint a;
      longint p;
      bit     s;
      a = 1024;
      s = 1'b0;
      for (int i = 0; i < n; i++) begin
         p = a * longint'(x);
`ifdef FIXED_POW_ROUND_EN
         p = p + 512;
`endif
         p = p / 1024;
         if (s || p > 64'd1048575) begin
            s = 1'b1;
            a = 1048575;
         end else begin
            a = p;
         end
      end
      return {s, a[19:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver: called just after a rising edge; returns just after the accepting edge
   task automatic start_op(input logic [19:0] x, input logic [2:0] n);
      exp_q.push_back(model(x, int'(n)));
      in_valid  = 1'b1;
      in_data_1 = x;
      in_data_2 = n;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_data_1 = 20'($urandom);
      in_data_2 = 3'($urandom);
   endtask

   // scoreboard: waits for out_valid, checks latency and result; leaves us in the out_valid cycle
   task automatic wait_result(input string tag, input int n, input int k0);
      logic [20:0] e;
      int lat;
      bit got;
      lat = 0;
      got = 1'b0;
      for (int k = k0 + 1; k <= 24 && !got; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            got = 1'b1;
            lat = k;
         end else begin
            check({tag, "_idle_out"}, {11'b0, out_ovf, out_data}, 32'h0);
         end
      end
      check({tag, "_latency"}, lat, n + 1);
      e = exp_q.pop_front();
      check({tag, "_data"}, {12'b0, out_data}, {12'b0, e[19:0]});
      check({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, e[20]});
   endtask

   initial begin
      logic [19:0] rx;
      logic [2:0]  rn;
      int          seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data_1 = '0;
      in_data_2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", {31'b0, out_valid}, 32'h0);
      check("reset_data", {12'b0, out_data}, 32'h0);
      check("reset_ovf", {31'b0, out_ovf}, 32'h0);
      rst_n = 1'b1;

      // basic power 2.0^3
      start_op(20'h00800, 3'd3);
      wait_result("basic", 3, 0);
      check("basic_const", {12'b0, out_data}, 32'h02000);
      @(posedge clk);
      #1;
      check("basic_pulse", {31'b0, out_valid}, 32'h0);

      start_op(20'h00600, 3'd2);
      wait_result("frac15", 2, 0);
      check("frac15_const", {12'b0, out_data}, 32'h00900);
      start_op(20'h00200, 3'd7);
      wait_result("frac05", 7, 0);
      check("frac05_const", {12'b0, out_data}, 32'h00008);

      start_op(20'h3FFFF, 3'd0);
      wait_result("nzero", 0, 0);
      check("nzero_const", {12'b0, out_data}, 32'h00400);
      start_op(20'h00000, 3'd5);
      wait_result("xzero", 5, 0);
      check("xzero_const", {12'b0, out_data}, 32'h00000);

      start_op(20'h08000, 3'd2);
      wait_result("sat2", 2, 0);
      check("sat2_const", {11'b0, out_ovf, out_data}, 32'h1FFFFF);
      start_op(20'h08000, 3'd7);
      wait_result("sat7", 7, 0);
      check("sat7_const", {11'b0, out_ovf, out_data}, 32'h1FFFFF);

      start_op(20'h00017, 3'd2);
      wait_result("round", 2, 0);
`ifdef FIXED_POW_ROUND_EN
      check("round_const", {12'b0, out_data}, 32'h00001);
`else
      check("round_const", {12'b0, out_data}, 32'h00000);
`endif

      // strobe during MUL must be dropped
      start_op(20'h00600, 3'd4);
      in_valid  = 1'b1;
      in_data_1 = 20'h00800;
      in_data_2 = 3'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_result("ignore", 4, 1);
      seen = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("ignore_extra", seen, 0);

      // back-to-back acceptance on the out_valid cycle
      start_op(20'h00500, 3'd2);
      wait_result("b2b_a", 2, 0);
      start_op(20'h00480, 3'd3);
      wait_result("b2b_b", 3, 0);

      // reset mid-MUL: no result afterwards
      start_op(20'h00800, 3'd7);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_out", {10'b0, out_valid, out_ovf, out_data}, 32'h0);
      void'(exp_q.pop_front());
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("rst_mid_noresult", seen, 0);

      // reset while out_valid high clears outputs without a clock
      start_op(20'h08000, 3'd1);
      wait_result("rst_ov", 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_ov_clear", {10'b0, out_valid, out_ovf, out_data}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      start_op(20'h00600, 3'd3);
      wait_result("after_rst", 3, 0);

      // randomized operations with random gaps
      for (int i = 0; i < 40; i++) begin
         rx = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 20'hFFFFF))
                                          : 20'($urandom_range(0, 20'h7FF));
         rn = 3'($urandom_range(0, 7));
         start_op(rx, rn);
         wait_result("rnd", int'(rn), 0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
